// File: rtl/alu_serial_seq.sv
`timescale 1ns/1ps
// Bit-serial AND/OR/ADD/SUB, LSB first; done pulses WIDTH cycles after the start edge, no backpressure.
// Optional ovf port and its logic exist only when ALU_SERIAL_OVF_EN is defined.
module alu_serial_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
`ifdef ALU_SERIAL_OVF_EN
   output logic             ovf,
`endif
   output logic             zero
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] r_result;
   logic [1:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic             r_carry;
   logic             r_cout;
   logic             r_zero;
`ifdef ALU_SERIAL_OVF_EN
   logic             r_ovf;
`endif

   logic             w_arith;
   logic             w_b_eff;
   logic             w_bit;
   logic             w_carry_nxt;
   logic             w_last;
   logic [WIDTH-1:0] w_sh_nxt;

   // One-bit slice: SUB is a + ~b + 1, the +1 comes from the preset carry.
   always_comb begin
      w_arith     = r_op[1];
      w_b_eff     = r_b[0] ^ (r_op == 2'b11);
      w_bit       = 1'b0;
      w_carry_nxt = 1'b0;
      case (r_op)
         2'b00:   w_bit = r_a[0] & r_b[0];
         2'b01:   w_bit = r_a[0] | r_b[0];
         default: begin
            w_bit       = r_a[0] ^ w_b_eff ^ r_carry;
            w_carry_nxt = (r_a[0] & w_b_eff) | (r_carry & (r_a[0] ^ w_b_eff));
         end
      endcase
      w_sh_nxt = {w_bit, r_sh[WIDTH-1:1]};
      w_last   = (r_cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sh     <= '0;
         r_result <= '0;
         r_op     <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_cout   <= 1'b0;
         r_zero   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
         r_ovf    <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_op    <= op;
                  r_sh    <= '0;
                  r_cnt   <= '0;
                  r_carry <= (op == 2'b11);
               end
            end
            S_RUN: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_sh    <= w_sh_nxt;
               r_carry <= w_carry_nxt;
               r_cnt   <= r_cnt + CW'(1);
               // On the MSB step r_carry is the carry into the MSB.
               if (w_last) begin
                  r_result <= w_sh_nxt;
                  r_cout   <= w_carry_nxt;
                  r_zero   <= (w_sh_nxt == '0);
`ifdef ALU_SERIAL_OVF_EN
                  r_ovf    <= w_arith & (r_carry ^ w_carry_nxt);
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign result = r_result;
   assign cout   = r_cout;
   assign zero   = r_zero;
`ifdef ALU_SERIAL_OVF_EN
   assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
`timescale 1ns/1ps
// Bench for alu_serial_seq: fixed vector table, random ops against an arithmetic model, multi-cycle corner sequences.
module tb_alu_serial_seq;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         zero;
`ifdef ALU_SERIAL_OVF_EN
   logic         ovf;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_serial_seq #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
`ifdef ALU_SERIAL_OVF_EN
      .ovf    (ovf),
`endif
      .zero   (zero)
   );

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] r;
      logic         c;
      logic         z;
      logic         v;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Reference: plain modular arithmetic, signed-overflow from operand/result signs.
   function automatic void model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic c, output logic z, output logic v);
      logic [W:0] s;
      r = '0; c = 1'b0; v = 1'b0;
      case (o)
         2'b00: r = x & y;
         2'b01: r = x | y;
         2'b10: begin
            s = {1'b0, x} + {1'b0, y};
            r = s[W-1:0];
            c = s[W];
            v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
         end
         default: begin
            r = x - y;
            c = (x >= y);
            v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
         end
      endcase
      z = (r == '0);
   endfunction

   task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] er, input logic ec, input logic ez, input logic ev);
      int cyc;
      bit seen;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom); op = 2'($urandom);
      check({nm, " busy"}, 32'(busy), 32'd1);
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < W + 4) begin
         @(posedge clk); #1;
         cyc++;
         if (done) seen = 1;
      end
      check({nm, " done_seen"}, 32'(seen), 32'd1);
      check({nm, " latency"}, 32'(cyc), 32'(W));
      check({nm, " busy_in_done"}, 32'(busy), 32'd0);
      check({nm, " result"}, 32'(result), 32'(er));
      check({nm, " cout"}, 32'(cout), 32'(ec));
      check({nm, " zero"}, 32'(zero), 32'(ez));
`ifdef ALU_SERIAL_OVF_EN
      check({nm, " ovf"}, 32'(ovf), 32'(ev));
`else
      if (ev === 1'bx) $display("note: ovf expectation undefined for %s", nm);
`endif
      @(posedge clk); #1;
      check({nm, " done_one_cycle"}, 32'(done), 32'd0);
      check({nm, " result_hold"}, 32'(result), 32'(er));
   endtask

   initial begin
      logic [W-1:0] mr;
      logic         mc, mz, mv;
      int           nd;
      int           k;
      int           cyc;
      int           t[3];
      logic [W-1:0] rres;

      vecs[0] = '{2'b00, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{2'b11, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{2'b01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{2'b11, 8'h33, 8'h33, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{2'b01, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst result", 32'(result), 32'd0);
      check("rst cout", 32'(cout), 32'd0);
      check("rst zero", 32'(zero), 32'd0);
`ifdef ALU_SERIAL_OVF_EN
      check("rst ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].v);
      end

      for (int i = 0; i < 40; i++) begin
         logic [1:0]   ro;
         logic [W-1:0] ra, rb;
         ro = 2'($urandom);
         ra = W'($urandom);
         rb = W'($urandom);
         model(ro, ra, rb, mr, mc, mz, mv);
         run_op($sformatf("rnd%0d", i), ro, ra, rb, mr, mc, mz, mv);
      end

      // start re-pulsed mid-operation with different operands must be ignored
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 8'h12; b = 8'h34;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 8'h00; b = 8'h00;
      @(posedge clk); #1;
      start = 1'b0;
      nd = 0; rres = '0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         if (done) begin
            nd++;
            rres = result;
         end
      end
      check("midstart done_count", 32'(nd), 32'd1);
      check("midstart result", 32'(rres), 32'h46);

      // back-to-back with start held high
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 8'h01; b = 8'h02;
      k = 0; cyc = 0;
      while (k < 3 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (done) begin
            t[k] = cyc;
            k++;
         end
      end
      start = 1'b0;
      check("b2b done_count", 32'(k), 32'd3);
      if (k == 3) begin
         check("b2b spacing0", 32'(t[1] - t[0]), 32'(W + 2));
         check("b2b spacing1", 32'(t[2] - t[1]), 32'(W + 2));
      end
      check("b2b result", 32'(result), 32'h03);
      repeat (2) @(posedge clk);

      // reset asserted mid-ADD aborts with no done and clears outputs
      @(negedge clk);
      start = 1'b1; op = 2'b10; a = 8'h10; b = 8'h20;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst busy", 32'(busy), 32'd0);
      check("arst done", 32'(done), 32'd0);
      check("arst result", 32'(result), 32'd0);
      check("arst cout", 32'(cout), 32'd0);
      check("arst zero", 32'(zero), 32'd0);
`ifdef ALU_SERIAL_OVF_EN
      check("arst ovf", 32'(ovf), 32'd0);
`endif
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(posedge clk); #1;
         if (done) nd++;
      end
      check("arst no_done", 32'(nd), 32'd0);
      run_op("after_rst", 2'b10, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
